// File: rtl/mips_pkg.sv
// Shared pipeline constants: forwarding-mux select codes and hazard FSM encoding.
package mips_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam int unsigned STATS_W = 16;

   typedef enum logic {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Operand forwarding select for one ALU input; the younger EX/MEM result beats MEM/WB.
module fwd_select
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] src_i,
   input  logic                  ex_mem_reg_write_i,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
   input  logic                  mem_wb_reg_write_i,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd_i,
   output logic [1:0]            sel_o
);

   // r0 is hard-wired zero, so a write to it never forwards
   always_comb begin
      sel_o = FWD_RF;
      if (ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == src_i)) begin
         sel_o = FWD_EXMEM;
      end else if (mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == src_i)) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding plus load-use stall FSM sized for MEM_LATENCY stall cycles.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_forward_unit
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_mem_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic                  mem_wb_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic [REG_ADDR_W-1:0] id_ex_rs,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic                  branch_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble,
   output logic                  stall_active,
   output logic [15:0]           stall_cycles
);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_a, sel_b;
   logic             hz_c;
   logic             stall_raw_c;
   logic             stall_c;

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src_i              (id_ex_rs),
      .ex_mem_reg_write_i (ex_mem_reg_write),
      .ex_mem_rd_i        (ex_mem_rd),
      .mem_wb_reg_write_i (mem_wb_reg_write),
      .mem_wb_rd_i        (mem_wb_rd),
      .sel_o              (sel_a)
   );

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src_i              (id_ex_rt),
      .ex_mem_reg_write_i (ex_mem_reg_write),
      .ex_mem_rd_i        (ex_mem_rd),
      .mem_wb_reg_write_i (mem_wb_reg_write),
      .mem_wb_rd_i        (mem_wb_rd),
      .sel_o              (sel_b)
   );

   assign hz_c = id_ex_mem_read && (id_ex_rt != '0) &&
                 ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

   // Branch flush outranks the load-use stall in both states
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_raw_c = 1'b0;
      case (state_q)
         HZ_IDLE: begin
            if (hz_c && !branch_flush) begin
               stall_raw_c = 1'b1;
               if (MEM_LATENCY > 1) begin
                  state_d = HZ_STALL;
                  cnt_d   = CNT_W'(MEM_LATENCY - 1);
               end
            end
         end
         HZ_STALL: begin
            if (branch_flush) begin
               state_d = HZ_IDLE;
               cnt_d   = '0;
            end else begin
               stall_raw_c = 1'b1;
               cnt_d       = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = HZ_IDLE;
               end
            end
         end
         default: begin
            state_d = HZ_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= HZ_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // All outputs sit at their reset values whenever rst_n is low
   assign stall_c      = stall_raw_c && rst_n;
   assign fwd_a        = rst_n ? sel_a : FWD_RF;
   assign fwd_b        = rst_n ? sel_b : FWD_RF;
   assign pc_write     = !stall_c;
   assign if_id_write  = !stall_c;
   assign id_ex_bubble = stall_c;
   assign stall_active = (state_q == HZ_STALL) && rst_n;

`ifdef HAZARD_STATS_EN
   logic [STATS_W-1:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (stall_c && (stat_q != {STATS_W{1'b1}})) begin
         stat_d = stat_q + STATS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stall_cycles = rst_n ? stat_q : '0;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: three instances (MEM_LATENCY 1, 3, 4) share stimulus and are
// compared against a remaining-stall-cycles model of the forwarding/stall rules.
module tb_hazard_forward_unit;

   localparam int unsigned NI = 3;

   typedef struct packed {
      logic [1:0]        fa;
      logic [1:0]        fb;
      logic [2:0]        stall;
      logic [2:0]        active;
      logic [2:0][15:0]  cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       exw = 1'b0, mww = 1'b0, memrd = 1'b0, bf = 1'b0;
   logic [4:0] exrd = '0, mwrd = '0, rs = '0, rt = '0, ifrs = '0, ifrt = '0;

   logic [1:0]  fa   [NI];
   logic [1:0]  fb   [NI];
   logic        pcw  [NI];
   logic        ifw  [NI];
   logic        bub  [NI];
   logic        act  [NI];
   logic [15:0] cyc  [NI];

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   int unsigned ml_tab [NI] = '{1, 3, 4};
   int unsigned rem    [NI] = '{0, 0, 0};
   int unsigned m_cyc  [NI] = '{0, 0, 0};

   always #5 clk = ~clk;

   hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LATENCY(1), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ex_mem_reg_write(exw), .ex_mem_rd(exrd),
      .mem_wb_reg_write(mww), .mem_wb_rd(mwrd), .id_ex_rs(rs), .id_ex_rt(rt),
      .id_ex_mem_read(memrd), .if_id_rs(ifrs), .if_id_rt(ifrt), .branch_flush(bf),
      .fwd_a(fa[0]), .fwd_b(fb[0]), .pc_write(pcw[0]), .if_id_write(ifw[0]),
      .id_ex_bubble(bub[0]), .stall_active(act[0]), .stall_cycles(cyc[0]));

   hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ex_mem_reg_write(exw), .ex_mem_rd(exrd),
      .mem_wb_reg_write(mww), .mem_wb_rd(mwrd), .id_ex_rs(rs), .id_ex_rt(rt),
      .id_ex_mem_read(memrd), .if_id_rs(ifrs), .if_id_rt(ifrt), .branch_flush(bf),
      .fwd_a(fa[1]), .fwd_b(fb[1]), .pc_write(pcw[1]), .if_id_write(ifw[1]),
      .id_ex_bubble(bub[1]), .stall_active(act[1]), .stall_cycles(cyc[1]));

   hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LATENCY(4), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ex_mem_reg_write(exw), .ex_mem_rd(exrd),
      .mem_wb_reg_write(mww), .mem_wb_rd(mwrd), .id_ex_rs(rs), .id_ex_rt(rt),
      .id_ex_mem_read(memrd), .if_id_rs(ifrs), .if_id_rt(ifrt), .branch_flush(bf),
      .fwd_a(fa[2]), .fwd_b(fb[2]), .pc_write(pcw[2]), .if_id_write(ifw[2]),
      .id_ex_bubble(bub[2]), .stall_active(act[2]), .stall_cycles(cyc[2]));

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (exw && exrd != 5'd0 && exrd == src) return 2'b10;
      if (mww && mwrd != 5'd0 && mwrd == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check(input string name, input int idx, input logic [15:0] got,
                        input logic [15:0] want);
      n_checks++;
      if (got !== want)
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, idx, got, want, $time);
      else
         n_pass++;
   endtask

   // Apply one cycle of stimulus, predict this cycle's outputs, advance the model past the edge
   task automatic drive(input logic r, input logic ew, input logic [4:0] erd,
                        input logic mw, input logic [4:0] mrd,
                        input logic [4:0] s, input logic [4:0] t, input logic mr,
                        input logic [4:0] is, input logic [4:0] it, input logic b);
      exp_t e;
      logic hz, st;
      @(posedge clk);
      #1;
      rst_n = r; exw = ew; exrd = erd; mww = mw; mwrd = mrd;
      rs = s; rt = t; memrd = mr; ifrs = is; ifrt = it; bf = b;
      e    = '0;
      e.fa = r ? ref_fwd(s) : 2'b00;
      e.fb = r ? ref_fwd(t) : 2'b00;
      hz   = mr && t != 5'd0 && (t == is || t == it);
      for (int i = 0; i < NI; i++) begin
         e.active[i] = r && rem[i] > 0;
`ifdef HAZARD_STATS_EN
         e.cyc[i] = r ? 16'(m_cyc[i]) : 16'd0;
`endif
         if (rem[i] == 0) begin
            st = hz && !b;
            if (st) rem[i] = ml_tab[i] - 1;
         end else if (b) begin
            st = 1'b0;
            rem[i] = 0;
         end else begin
            st = 1'b1;
            rem[i] = rem[i] - 1;
         end
         e.stall[i] = r && st;
         if (!r) begin
            rem[i]   = 0;
            m_cyc[i] = 0;
         end else if (st && m_cyc[i] < 65535) begin
            m_cyc[i] = m_cyc[i] + 1;
         end
      end
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < NI; i++) begin
               check("fwd_a", i, 16'(fa[i]), 16'(e.fa));
               check("fwd_b", i, 16'(fb[i]), 16'(e.fb));
               check("pc_write", i, 16'(pcw[i]), 16'(!e.stall[i]));
               check("if_id_write", i, 16'(ifw[i]), 16'(!e.stall[i]));
               check("id_ex_bubble", i, 16'(bub[i]), 16'(e.stall[i]));
               check("stall_active", i, 16'(act[i]), 16'(e.active[i]));
               check("stall_cycles", i, cyc[i], e.cyc[i]);
            end
         end
      end
   end

   initial begin : stimulus
      // reset
      drive(0, 1, 5'd5, 1, 5'd5, 5'd5, 5'd5, 1, 5'd5, 5'd5, 0);
      drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0);
      // forwarding priority and r0 exclusion
      drive(1, 1, 5'd5, 1, 5'd5, 5'd5, 5'd0, 0, 5'd0, 5'd0, 0);
      drive(1, 0, 5'd5, 1, 5'd5, 5'd5, 5'd5, 0, 5'd0, 5'd0, 0);
      drive(1, 1, 5'd0, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0);
      // load-use: one hazard cycle followed by bubbles
      drive(1, 0, 5'd0, 0, 5'd0, 5'd1, 5'd3, 1, 5'd3, 5'd7, 0);
      repeat (5) drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd3, 5'd7, 0);
      // branch flush on the second stall cycle
      drive(1, 0, 5'd0, 0, 5'd0, 5'd1, 5'd3, 1, 5'd3, 5'd7, 0);
      drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd3, 5'd7, 1);
      repeat (3) drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd3, 5'd7, 0);
      // reset in the middle of a stall
      drive(1, 0, 5'd0, 0, 5'd0, 5'd1, 5'd3, 1, 5'd7, 5'd3, 0);
      drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd7, 5'd3, 0);
      drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd7, 5'd3, 0);
      repeat (2) drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0);
      // randomized traffic over a small register window to force collisions
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 39) != 0),
               1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0));
      end
      repeat (4) @(negedge clk);
      check("scoreboard_drained", 0, 16'(sb_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
